ps2_kbd_tx: RTL and testbench

Device-side PS/2 keyboard transmitter: the sending end of the PS/2 link that our keyboard receiver peripheral consumes. Scan-code bytes are queued through a valid/ready port into an internal FIFO. Each byte is serialised as an 11-bit PS/2 frame on `ps2_clk`/`ps2_data`, with the device generating the clock. Used as an on-FPGA keyboard emulator and as the stimulus source for receiver-side verification.

---
 rtl/ps2_kbd_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queued scan codes leave as 11-bit frames
// on a device-generated clock, with host-inhibit abort and whole-frame resend.
module ps2_kbd_tx #(
  parameter int CLK_DIV  = 8,
  parameter int IDLE_GAP = 16,
  parameter int FIFO_AW  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wdata,
  input  logic       wvalid,
  output logic       wready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       done
);
  localparam int CNT_MAX = (CLK_DIV > IDLE_GAP) ? CLK_DIV : IDLE_GAP;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int PW      = FIFO_AW + 1;
  localparam int DEPTH   = 1 << FIFO_AW;

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(IDLE_GAP - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HIGH = 3'd1;
  localparam logic [2:0] S_LOW  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_INH  = 3'd4;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          empty, full, push, pop;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    idx, nxt_idx;
  logic [7:0]    hold;
  logic          hold_vld;
  logic [10:0]   frame;

  // FIFO: extra pointer bit distinguishes full from empty
  assign empty  = (wptr == rptr);
  assign full   = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                  (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign wready = !full;
  assign push   = wvalid && !full;
  // A held byte (aborted frame) always goes out before anything new is popped
  assign pop    = (state == S_IDLE) && !inhibit && !hold_vld && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[FIFO_AW-1:0]] <= wdata;
  end

  assign frame   = {1'b1, ~^hold, hold, 1'b0};
  assign nxt_idx = idx + 4'd1;
  assign busy    = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      hold     <= '0;
      hold_vld <= 1'b0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!inhibit && (hold_vld || !empty)) begin
            if (!hold_vld) begin
              hold     <= mem[rptr[FIFO_AW-1:0]];
              hold_vld <= 1'b1;
            end
            idx      <= '0;
            cnt      <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b0;
            state    <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (inhibit) begin
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            cnt      <= '0;
            state    <= S_INH;
          end else if (cnt == DIV_LAST) begin
            ps2_clk <= 1'b0;
            cnt     <= '0;
            state   <= S_LOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LOW: begin
          // Once the stop bit is on the wire the frame counts as delivered
          if (inhibit && idx != 4'd10) begin
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            cnt      <= '0;
            state    <= S_INH;
          end else if (cnt == DIV_LAST) begin
            ps2_clk <= 1'b1;
            cnt     <= '0;
            if (idx == 4'd10) begin
              done     <= 1'b1;
              hold_vld <= 1'b0;
              ps2_data <= 1'b1;
              state    <= S_GAP;
            end else begin
              idx      <= nxt_idx;
              ps2_data <= frame[nxt_idx];
              state    <= S_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (hold_vld && !inhibit) begin
              idx      <= '0;
              ps2_data <= 1'b0;
              state    <= S_HIGH;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_INH: begin
          if (!inhibit) begin
            cnt   <= '0;
            state <= S_GAP;
          end
        end
        default: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          cnt      <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: timeline model of the PS/2 waveform checked every cycle,
// a host-side frame decoder, and literal pins on the 0x1C frame timing.
module tb_ps2_kbd_tx;
  localparam int CD = 8, GAP = 16, AW = 3, DEPTH = 8;
  localparam int M_IDLE = 0, M_FRAME = 1, M_GAP = 2, M_INH = 3;

  logic clk = 0, reset = 1, wvalid = 0, inhibit = 0;
  logic [7:0] wdata = 0;
  logic wready, ps2_clk, ps2_data, busy, done;

  ps2_kbd_tx #(.CLK_DIV(CD), .IDLE_GAP(GAP), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .inhibit(inhibit), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // 0x1C with CLK_DIV=8: falling edges and sampled bits, relative to the accept edge
  int ft[11] = '{9, 25, 41, 57, 73, 89, 105, 121, 137, 153, 169};
  bit fb[11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};

  // Model: FIFO contents as a queue, frame waveform from elapsed time since start
  logic [7:0] mq[$];
  logic [7:0] hb;
  bit   hv = 0, m_ok = 0;
  int   mode = M_IDLE, t_s = 0, t_g = 0;
  logic e_clk = 1, e_dat = 1, e_done = 0;

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9) return ~^b;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : mdl
    int o, p;
    bit acc;
    cyc++;
    if (reset) begin
      mq.delete(); hv = 0; mode = M_IDLE; e_done = 0; m_ok = 1;
    end else if (m_ok) begin
      acc = wvalid && (mq.size() < DEPTH);
      e_done = 0;
      case (mode)
        M_IDLE: if (!inhibit && (hv || mq.size() > 0)) begin
          if (!hv) begin hb = mq.pop_front(); hv = 1; end
          mode = M_FRAME; t_s = cyc;
        end
        M_FRAME: begin
          p = cyc - t_s - 1;
          if (inhibit && !((p / (2*CD)) == 10 && (p % (2*CD)) >= CD)) mode = M_INH;
          else if (cyc - t_s == 22*CD) begin e_done = 1; hv = 0; mode = M_GAP; t_g = cyc; end
        end
        M_GAP: if (cyc - t_g == GAP) begin
          if (hv && !inhibit) begin mode = M_FRAME; t_s = cyc; end
          else mode = M_IDLE;
        end
        default: if (!inhibit) begin mode = M_GAP; t_g = cyc; end
      endcase
      if (acc) mq.push_back(wdata);
    end
    if (mode == M_FRAME) begin
      o = cyc - t_s;
      e_clk = (o % (2*CD)) < CD;
      e_dat = fbit(hb, o / (2*CD));
    end else begin
      e_clk = 1; e_dat = 1;
    end
  end

  // Per-cycle compare plus host receiver decoding on ps2_clk falling edges
  logic prev_clk = 1;
  logic [10:0] sh = '0;
  int nb = 0, hi = 0, done_cnt = 0, rx_err = 0;
  int fall_t[$], done_t[$];
  logic fall_b[$], rx_par[$];
  logic [7:0] rx_q[$];

  always @(posedge clk) begin : cmp
    logic e_wr, e_busy;
    #2;
    if (m_ok) begin
      e_wr   = (mq.size() < DEPTH);
      e_busy = (mode != M_IDLE) || (mq.size() > 0);
      n_cmp++;
      if ({ps2_clk, ps2_data, done, wready, busy} !== {e_clk, e_dat, e_done, e_wr, e_busy}) begin
        n_bad++;
        $display("FAIL cyc %0d clk/data/done/wready/busy got %b want %b", cyc,
                 {ps2_clk, ps2_data, done, wready, busy}, {e_clk, e_dat, e_done, e_wr, e_busy});
      end
      if (done) begin done_cnt++; done_t.push_back(cyc); end
      if (reset) nb = 0;
      else if (prev_clk && !ps2_clk) begin
        fall_t.push_back(cyc); fall_b.push_back(ps2_data);
        sh[nb] = ps2_data; nb++;
        if (nb == 11) begin
          if (sh[0] == 1'b0 && sh[10] == 1'b1 && (^sh[9:1]) == 1'b1) begin
            rx_q.push_back(sh[8:1]); rx_par.push_back(sh[9]);
          end else rx_err++;
          nb = 0;
        end
      end
      hi = ps2_clk ? hi + 1 : 0;
      if (hi > 2*CD) nb = 0;
      prev_clk = ps2_clk;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic put(input logic [7:0] b);
    int n = 0;
    @(negedge clk); wdata = b; wvalid = 1;
    while (!wready && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("put_timeout", 0, 1);
    @(posedge clk); #1; wvalid = 0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    @(negedge clk);
    while (busy && n < lim) begin @(negedge clk); n++; end
    if (n >= lim) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin : stim
    logic [7:0] exp_rx[$];
    int n0, s, d0, n;
    repeat (3) @(negedge clk);
    chk("rst_ps2_clk", ps2_clk, 1);
    chk("rst_ps2_data", ps2_data, 1);
    chk("rst_wready", wready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 0;
    repeat (2) @(negedge clk);

    // Single byte 0x1C: pinned edge timing and bit values
    fall_t.delete(); fall_b.delete(); done_t.delete();
    put(8'h1C); n0 = cyc; exp_rx.push_back(8'h1C);
    n = 0;
    while (done_cnt == 0 && n < 400) begin @(negedge clk); n++; end
    chk("1c_fall_count", fall_t.size(), 11);
    for (int k = 0; k < 11; k++) if (k < fall_t.size()) begin
      chk($sformatf("1c_fall_t%0d", k), fall_t[k] - n0, ft[k]);
      chk($sformatf("1c_bit%0d", k), fall_b[k], fb[k]);
    end
    chk("1c_done_t", (done_t.size() > 0) ? done_t[0] - n0 : -1, 177);

    // Parity boundaries
    put(8'h00); put(8'hFF); put(8'hF0);
    exp_rx.push_back(8'h00); exp_rx.push_back(8'hFF); exp_rx.push_back(8'hF0);
    wait_idle(3000);
    chk("rx_count_4", rx_q.size(), 4);
    if (rx_par.size() >= 4) begin
      chk("par_1c", rx_par[0], 0);
      chk("par_00", rx_par[1], 1);
      chk("par_ff", rx_par[2], 1);
      chk("par_f0", rx_par[3], 1);
    end

    // FIFO full while inhibited, then drain
    @(negedge clk); inhibit = 1;
    for (int i = 0; i < 8; i++) begin put(8'h10 + 8'(i)); exp_rx.push_back(8'h10 + 8'(i)); end
    @(negedge clk); chk("full_wready", wready, 0);
    fork
      put(8'h18);
      begin
        @(negedge clk); inhibit = 0;
        @(posedge clk); #1; chk("wready_after_pop", wready, 1);
      end
    join
    exp_rx.push_back(8'h18);
    wait_idle(5000);

    // Abort in bit-4 LOW, resend
    d0 = done_cnt;
    put(8'hA5); s = cyc + 1;
    wait_cyc(s + 9*CD + 2); inhibit = 1;
    @(posedge clk); #1;
    chk("abort_clk", ps2_clk, 1);
    chk("abort_data", ps2_data, 1);
    repeat (20) @(negedge clk); inhibit = 0;
    chk("abort_no_done", done_cnt - d0, 0);
    wait_idle(2000);
    chk("resend_one_done", done_cnt - d0, 1);
    exp_rx.push_back(8'hA5);

    // Inhibit during stop-bit LOW: delivered, no resend
    d0 = done_cnt;
    put(8'h3C); s = cyc + 1;
    wait_cyc(s + 21*CD + 2); inhibit = 1;
    repeat (30) @(negedge clk); inhibit = 0;
    wait_idle(2000);
    chk("stop_inh_one_done", done_cnt - d0, 1);
    exp_rx.push_back(8'h3C);

    // Reset mid-frame with bytes queued
    @(negedge clk); inhibit = 1;
    put(8'h51); put(8'h52); put(8'h53);
    @(negedge clk); inhibit = 0; s = cyc + 1;
    wait_cyc(s + 12*CD + 2); reset = 1;
    @(posedge clk); #1;
    chk("mid_rst_clk", ps2_clk, 1);
    chk("mid_rst_data", ps2_data, 1);
    chk("mid_rst_wready", wready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk); reset = 0; d0 = done_cnt;
    repeat (400) @(negedge clk);
    chk("mid_rst_no_frames", done_cnt - d0, 0);
    chk("mid_rst_idle", busy, 0);

    // Simultaneous write and pop at 7 entries, across pointer wrap
    @(negedge clk); inhibit = 1;
    for (int i = 0; i < 7; i++) begin put(8'h61 + 8'(i)); exp_rx.push_back(8'h61 + 8'(i)); end
    @(negedge clk); wdata = 8'h68; wvalid = 1; inhibit = 0;
    @(posedge clk); #1; wvalid = 0;
    exp_rx.push_back(8'h68);
    chk("simul_wready", wready, 1);
    put(8'h69); exp_rx.push_back(8'h69);
    @(negedge clk); chk("simul_full", wready, 0);
    wait_idle(5000);

    chk("rx_total", rx_q.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size(); i++)
      if (i < rx_q.size()) chk($sformatf("rx_byte%0d", i), rx_q[i], exp_rx[i]);
    chk("rx_framing_errors", rx_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
